// File: rtl/time_clock_ctrl.sv
// RUN/SET mode controller for the FND time clock: button edges, blink, auto-repeat, set timeout.
// All outputs registered; a button level sampled at edge k shows up on the outputs at edge k+2.
module time_clock_ctrl #(
   parameter int BLINK_HALF = 50_000_000,
   parameter int REPEAT_DLY = 100_000_000,
   parameter int REPEAT_PER = 20_000_000,
   parameter int TIMEOUT    = 1_000_000_000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_mode,
   input  logic       i_set,
   input  logic       i_up,
   output logic       o_run,
   output logic       o_disp_sel,
   output logic       o_inc_hour,
   output logic       o_inc_min,
   output logic       o_clr_sec,
   output logic [3:0] o_blank,
   output logic [1:0] o_state
);

   localparam int HOLD_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
   localparam logic [HW-1:0] DLY_LAST   = HW'(REPEAT_DLY - 1);
   localparam logic [HW-1:0] PER_LAST   = HW'(REPEAT_PER - 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      RUN_MS   = 2'd0,
      RUN_HM   = 2'd1,
      SET_HOUR = 2'd2,
      SET_MIN  = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [2:0]    sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
   logic [BW-1:0] blink_q, blink_d;
   logic          phase_q, phase_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          armed_q, armed_d;
   logic          rep_q, rep_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          run_q, run_d, sel_q, sel_d;
   logic          inc_hour_q, inc_hour_d, inc_min_q, inc_min_d, clr_q, clr_d;
   logic [3:0]    blank_q, blank_d;

   logic [2:0] btn_edge;
   logic       mode_edge, set_edge, up_edge, in_set, inc;

   // Button bit order in the sync chain: [2]=mode, [1]=set, [0]=up.
   assign btn_edge  = sync2_q & ~sync3_q;
   assign mode_edge = btn_edge[2];
   assign set_edge  = btn_edge[1] & ~btn_edge[2];
   assign up_edge   = btn_edge[0] & ~(|btn_edge[2:1]);
   assign in_set    = state_q[1];

   always_comb begin
      sync1_d = {i_mode, i_set, i_up};
      sync2_d = sync1_q;
      sync3_d = sync2_q;
      state_d = state_q;
      hold_d  = '0;
      armed_d = 1'b0;
      rep_d   = 1'b0;
      tmo_d   = '0;
      blink_d = '0;
      phase_d = 1'b0;
      inc     = 1'b0;

      case (state_q)
         RUN_MS:   if (mode_edge) state_d = RUN_HM;   else if (set_edge) state_d = SET_HOUR;
         RUN_HM:   if (mode_edge) state_d = RUN_MS;   else if (set_edge) state_d = SET_HOUR;
         SET_HOUR: if (mode_edge) state_d = RUN_HM;   else if (set_edge) state_d = SET_MIN;
         SET_MIN:  if (mode_edge || set_edge) state_d = RUN_HM;
      endcase

      // Up handling only while staying in a SET state, so no pulse straddles a transition.
      if (in_set && (state_d == state_q)) begin
         if (up_edge) begin
            inc     = 1'b1;
            armed_d = 1'b1;
         end else if (armed_q && sync2_q[0]) begin
            armed_d = 1'b1;
            rep_d   = rep_q;
            if (hold_q == (rep_q ? PER_LAST : DLY_LAST)) begin
               inc   = 1'b1;
               rep_d = 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end

         if (!inc && !(|btn_edge)) begin
            if (tmo_q == TMO_LAST) state_d = RUN_HM;
            else                   tmo_d   = tmo_q + 1'b1;
         end
      end

      // Entering a SET state or pulsing restarts the blink in its visible phase.
      if (state_d[1] && (state_d == state_q) && !inc) begin
         if (blink_q == BLINK_LAST) begin
            phase_d = ~phase_q;
         end else begin
            blink_d = blink_q + 1'b1;
            phase_d = phase_q;
         end
      end

      run_d      = ~state_d[1];
      sel_d      = (state_d != RUN_MS);
      inc_hour_d = inc && (state_q == SET_HOUR);
      inc_min_d  = inc && (state_q == SET_MIN);
      clr_d      = in_set && !state_d[1];
      blank_d    = 4'b0000;
      if (phase_d) blank_d = (state_d == SET_HOUR) ? 4'b1100 : 4'b0011;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= RUN_MS;
         sync1_q    <= '0;
         sync2_q    <= '0;
         sync3_q    <= '0;
         blink_q    <= '0;
         phase_q    <= 1'b0;
         hold_q     <= '0;
         armed_q    <= 1'b0;
         rep_q      <= 1'b0;
         tmo_q      <= '0;
         run_q      <= 1'b1;
         sel_q      <= 1'b0;
         inc_hour_q <= 1'b0;
         inc_min_q  <= 1'b0;
         clr_q      <= 1'b0;
         blank_q    <= 4'b0000;
      end else begin
         state_q    <= state_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         sync3_q    <= sync3_d;
         blink_q    <= blink_d;
         phase_q    <= phase_d;
         hold_q     <= hold_d;
         armed_q    <= armed_d;
         rep_q      <= rep_d;
         tmo_q      <= tmo_d;
         run_q      <= run_d;
         sel_q      <= sel_d;
         inc_hour_q <= inc_hour_d;
         inc_min_q  <= inc_min_d;
         clr_q      <= clr_d;
         blank_q    <= blank_d;
      end
   end

   assign o_run      = run_q;
   assign o_disp_sel = sel_q;
   assign o_inc_hour = inc_hour_q;
   assign o_inc_min  = inc_min_q;
   assign o_clr_sec  = clr_q;
   assign o_blank    = blank_q;
   assign o_state    = state_q;

endmodule

// File: tb/tb_time_clock_ctrl.sv
// Directed bench for time_clock_ctrl: per-cycle expected output vectors are queued, then
// popped and compared at each falling edge while the matching button stimulus is applied.
module tb_time_clock_ctrl;

   logic       i_clk = 1'b0;
   logic       i_reset = 1'b0;
   logic       i_mode = 1'b0, i_set = 1'b0, i_up = 1'b0;
   logic       o_run, o_disp_sel, o_inc_hour, o_inc_min, o_clr_sec;
   logic [3:0] o_blank;
   logic [1:0] o_state;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      string       tag;
      logic [10:0] val;
   } exp_t;
   exp_t sb[$];

   time_clock_ctrl #(
      .BLINK_HALF(4), .REPEAT_DLY(8), .REPEAT_PER(3), .TIMEOUT(40)
   ) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_mode(i_mode), .i_set(i_set), .i_up(i_up),
      .o_run(o_run), .o_disp_sel(o_disp_sel), .o_inc_hour(o_inc_hour), .o_inc_min(o_inc_min),
      .o_clr_sec(o_clr_sec), .o_blank(o_blank), .o_state(o_state)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [10:0] mk(input logic [1:0] st, input logic run, input logic sel,
                                      input logic ih, input logic im, input logic clr,
                                      input logic [3:0] blk);
      return {st, run, sel, ih, im, clr, blk};
   endfunction

   function automatic logic [10:0] obs();
      return {o_state, o_run, o_disp_sel, o_inc_hour, o_inc_min, o_clr_sec, o_blank};
   endfunction

   localparam logic [10:0] V_RMS = {2'd0, 1'b1, 1'b0, 3'b000, 4'b0000};
   localparam logic [10:0] V_RHM = {2'd1, 1'b1, 1'b1, 3'b000, 4'b0000};
   localparam logic [10:0] V_CLR = {2'd1, 1'b1, 1'b1, 3'b001, 4'b0000};
   localparam logic [10:0] V_SHV = {2'd2, 1'b0, 1'b1, 3'b000, 4'b0000};
   localparam logic [10:0] V_SHB = {2'd2, 1'b0, 1'b1, 3'b000, 4'b1100};
   localparam logic [10:0] V_SHP = {2'd2, 1'b0, 1'b1, 3'b100, 4'b0000};
   localparam logic [10:0] V_SMV = {2'd3, 1'b0, 1'b1, 3'b000, 4'b0000};
   localparam logic [10:0] V_SMB = {2'd3, 1'b0, 1'b1, 3'b000, 4'b0011};
   localparam logic [10:0] V_SMP = {2'd3, 1'b0, 1'b1, 3'b010, 4'b0000};

   task automatic ex(input string tag, input logic [10:0] val, input int n);
      exp_t e;
      e.tag = tag;
      e.val = val;
      for (int i = 0; i < n; i++) sb.push_back(e);
   endtask

   task automatic tick(input logic m, input logic s, input logic u);
      exp_t e;
      logic [10:0] o;
      i_mode = m;
      i_set  = s;
      i_up   = u;
      @(negedge i_clk);
      n_assert++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL sb_underflow observed=%b required=<queued entry>", obs());
      end else begin
         e = sb.pop_front();
         o = obs();
         assert (o === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%b required=%b", e.tag, o, e.val);
         end
      end
   endtask

   task automatic press(input logic m, input logic s, input logic u, input int n);
      for (int i = 0; i < n; i++) tick(m, s, u);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] o;
      repeat (3) @(negedge i_clk);
      o = obs();
      n_assert++;
      assert (o === V_RMS) else begin
         n_fail++;
         $error("FAIL reset_state observed=%b required=%b", o, V_RMS);
      end
      i_reset = 1'b1;

      ex("idle", V_RMS, 20); idle(20);
      ex("mode1_pre", V_RMS, 2); ex("mode1_hm", V_RHM, 8); press(1, 0, 0, 5); idle(5);
      ex("mode2_pre", V_RHM, 2); ex("mode2_ms", V_RMS, 8); press(1, 0, 0, 5); idle(5);

      ex("set1_pre", V_RMS, 2); ex("sh_vis", V_SHV, 4); ex("sh_blank", V_SHB, 4);
      press(0, 1, 0, 3); idle(7);
      ex("set2_pre", V_SHV, 2); ex("sm_vis", V_SMV, 4); ex("sm_blank", V_SMB, 4);
      press(0, 1, 0, 3); idle(7);
      ex("set3_pre", V_SMV, 2); ex("set3_clr", V_CLR, 1); ex("set3_hm", V_RHM, 7);
      press(0, 1, 0, 3); idle(7);

      ex("tap_pre", V_RHM, 2); ex("tap_shv", V_SHV, 4); ex("tap_shb", V_SHB, 2);
      press(0, 1, 0, 3); idle(5);
      for (int k = 0; k < 3; k++) begin
         ex("tap_blank", V_SHB, 2); ex("tap_pulse", V_SHP, 1);
         ex("tap_vis", V_SHV, 3); ex("tap_after", V_SHB, 2);
         press(0, 0, 1, 1); idle(7);
      end

      ex("tosm_pre", V_SHB, 2); ex("tosm_vis", V_SMV, 4); ex("tosm_blank", V_SMB, 2);
      press(0, 1, 0, 3); idle(5);
      ex("hold_pre", V_SMB, 2); ex("hold_p0", V_SMP, 1); ex("hold_v0", V_SMV, 3);
      ex("hold_b0", V_SMB, 4); ex("hold_p8", V_SMP, 1); ex("hold_v8", V_SMV, 2);
      ex("hold_p11", V_SMP, 1); ex("hold_v11", V_SMV, 2); ex("hold_p14", V_SMP, 1);
      ex("hold_v14", V_SMV, 2); ex("hold_p17", V_SMP, 1); ex("rel_vis", V_SMV, 3);
      ex("rel_blank", V_SMB, 4); ex("rel_vis2", V_SMV, 3);
      press(0, 0, 1, 20); idle(10);

      ex("smexit_v", V_SMV, 1); ex("smexit_b", V_SMB, 1); ex("smexit_clr", V_CLR, 1);
      ex("smexit_hm", V_RHM, 5); press(1, 0, 0, 3); idle(5);

      ex("toms_pre", V_RHM, 2); ex("toms", V_RMS, 6); press(1, 0, 0, 3); idle(5);
      ex("prio_pre", V_RMS, 2); ex("prio_mode_wins", V_RHM, 6); press(1, 1, 0, 3); idle(5);

      ex("tmo_pre", V_RHM, 2);
      for (int k = 0; k < 5; k++) begin
         ex("tmo_vis", V_SHV, 4); ex("tmo_blank", V_SHB, 4);
      end
      ex("tmo_clr", V_CLR, 1); ex("tmo_hm", V_RHM, 3);
      press(0, 1, 0, 3); idle(43);

      ex("rst_sh_pre", V_RHM, 2); ex("rst_shv", V_SHV, 4); ex("rst_shb", V_SHB, 2);
      press(0, 1, 0, 3); idle(5);
      ex("rst_sm_pre", V_SHB, 2); ex("rst_smv", V_SMV, 4); ex("rst_smb", V_SMB, 2);
      press(0, 1, 0, 3); idle(5);
      ex("rst_hold_pre", V_SMB, 2); ex("rst_hold_p0", V_SMP, 1);
      ex("rst_hold_v", V_SMV, 3); ex("rst_hold_b", V_SMB, 4);
      press(0, 0, 1, 10);

      #2;
      i_reset = 1'b0;
      #1;
      o = obs();
      n_assert++;
      assert (o === V_RMS) else begin
         n_fail++;
         $error("FAIL async_reset observed=%b required=%b", o, V_RMS);
      end
      @(negedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b1;
      ex("post_rst_up_held", V_RMS, 23); press(0, 0, 1, 20); idle(3);

      n_assert++;
      assert (sb.size() == 0) else begin
         n_fail++;
         $error("FAIL sb_leftover observed=%0d required=0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/time_clock_ctrl.md
Name: time_clock_ctrl

Overview:
- Mode/set controller for the FND time clock.
- Turns three debounced push-button levels (mode, set, up) into four outputs for the time counter and FND scan driver:
  - run enable
  - display-page select
  - field increment pulses
  - per-digit blink blanking
- Owns the RUN/SET state machine, blink timing, up-button auto-repeat and set-mode timeout. No time arithmetic is done here.

Parameters:
BLINK_HALF, 50_000_000, cycles per blink half-period (visible/blank)
REPEAT_DLY, 100_000_000, cycles up must be held after first pulse before auto-repeat starts
REPEAT_PER, 20_000_000, cycles between auto-repeat pulses
TIMEOUT, 1_000_000_000, idle cycles in a SET state before forced exit

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous active-low reset
i_mode  in  1  mode button level, debounced, active-high
i_set  in  1  set button level, debounced, active-high
i_up  in  1  up button level, debounced, active-high
o_run  out  1  time counter enable
o_disp_sel  out  1  0 = MM:SS page, 1 = HH:MM page
o_inc_hour  out  1  one-cycle hour increment pulse
o_inc_min  out  1  one-cycle minute increment pulse
o_clr_sec  out  1  one-cycle seconds clear pulse
o_blank  out  4  per-digit blank mask, bit3 = leftmost digit
o_state  out  2  current state code, for debug

Behaviour:
- Reset (i_reset = 0, asynchronous, takes effect mid-operation):
  - state RUN_MS (2'd0); all counters 0; synchronizers 0.
  - o_run = 1, o_disp_sel = 0, o_inc_hour/o_inc_min/o_clr_sec = 0, o_blank = 4'b0000.
- Input path and edge detect:
  - Each button passes through a 2-flop synchronizer plus a history flop.
  - Edge = s2 & ~s3.
  - Input sampled high at edge k → state and registered outputs change at edge k+2.
- Priority of same-cycle edges: mode > set > up. Lower-priority edges in that cycle are discarded.
- All outputs are registered.
- States (o_state code; o_run, o_disp_sel; o_blank when blink phase is blank):
  - RUN_MS (0): run = 1, sel = 0. mode → RUN_HM. set → SET_HOUR.
  - RUN_HM (1): run = 1, sel = 1. mode → RUN_MS. set → SET_HOUR.
  - SET_HOUR (2): run = 0, sel = 1, blank = 1100. up → o_inc_hour pulse. set → SET_MIN. mode → RUN_HM.
  - SET_MIN (3): run = 0, sel = 1, blank = 0011. up → o_inc_min pulse. set → RUN_HM. mode → RUN_HM.
- In RUN states: up is ignored, o_blank = 0000, blink and timeout counters are held at 0.
- Leaving SET_HOUR or SET_MIN by any path (set, mode or timeout):
  - o_clr_sec pulses high for exactly the first cycle in RUN_HM.
- Blink:
  - Counter counts 0..BLINK_HALF-1; phase toggles on wrap.
  - Phase 0 = visible (o_blank = 0000), phase 1 = blank (mask as listed per state).
  - Counter and phase reset to 0/visible on entering a SET state and on every increment pulse, so digits stay lit while adjusting.
- Auto-repeat:
  - Up edge gives the first pulse.
  - While up stays high, a hold counter runs. After REPEAT_DLY cycles an extra pulse is issued, then one every REPEAT_PER cycles.
  - Up low clears the hold counter.
  - A state change clears the hold counter; no pulse carries into the new state.
- Timeout:
  - Counter runs in SET states and clears on any mode/set/up edge or any increment pulse.
  - Reaching TIMEOUT-1 → next state RUN_HM, with o_clr_sec.
- Increment pulses never coincide with a state change; they are always exactly 1 cycle wide.
- Counter widths are $clog2 of the respective parameter. No counter may wrap to an unintended value.

Test Plan:
(Parameters for all scenarios: BLINK_HALF = 4, REPEAT_DLY = 8, REPEAT_PER = 3, TIMEOUT = 40.)
- Reset, then idle 20 cycles → o_state = 0, o_run = 1, o_disp_sel = 0, o_blank = 0000, no pulses. Pulse i_mode high 5 cycles → o_state = 1, o_disp_sel = 1 two edges after sampling. Press again → back to o_state = 0.
- Press set → o_state = 2, o_run = 0. o_blank toggles 0000 (4 cycles) / 1100 (4 cycles). Press set → o_state = 3, mask 0011. Press set → o_state = 1, o_clr_sec high exactly 1 cycle, o_run = 1.
- In SET_HOUR, tap up 3 times → exactly 3 single-cycle o_inc_hour pulses, o_inc_min = 0. o_blank = 0000 for 4 cycles after each pulse.
- In SET_MIN, hold up 20 cycles → pulses at edge-detect cycle, +8, +11, +14, +17 (5 total). Release → no further pulses.
- Raise i_mode and i_set in the same cycle while in RUN_MS → o_state = 1 (mode wins). In SET_HOUR, idle 40 cycles → o_state = 1 with one o_clr_sec pulse.
- Drive i_reset = 0 mid auto-repeat in SET_MIN → all outputs return to reset values immediately (asynchronously). After release, holding i_up yields no pulses.
